// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the controller state encoding and the default operand width.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // A single-bit operand still needs a one-bit counter.
    function automatic int cntWidth(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: difference and borrow for x - y - br_in.
module full_subtractor_bit (
    input  logic x,
    input  logic y,
    input  logic br_in,
    output logic d,
    output logic br_out
);

    logic w_xorXY;

    assign w_xorXY = x ^ y;
    assign d       = w_xorXY ^ br_in;
    assign br_out  = (~x & y) | (~w_xorXY & br_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes {b_out, diff} = a - b - b_in one bit per cycle, LSB first.
// A start in IDLE latches the operands; done pulses for one cycle when the result is loaded.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
);

    localparam int             CW   = cntWidth(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_aShift;
    logic [WIDTH-1:0] r_bShift;
    logic [WIDTH-1:0] r_dShift;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_bOut;
    logic             r_done;
    logic             r_ready;

    logic             w_d;
    logic             w_borrowNext;
    logic [WIDTH-1:0] w_dShiftNext;

    full_subtractor_bit u_cell (
        .x      (r_aShift[0]),
        .y      (r_bShift[0]),
        .br_in  (r_borrow),
        .d      (w_d),
        .br_out (w_borrowNext)
    );

    // New difference bits enter at the MSB so the LSB-first stream lands in place after WIDTH shifts.
    assign w_dShiftNext = WIDTH'({w_d, r_dShift} >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_aShift <= '0;
            r_bShift <= '0;
            r_dShift <= '0;
            r_borrow <= 1'b0;
            r_diff   <= '0;
            r_bOut   <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_aShift <= a;
                        r_bShift <= b;
                        r_borrow <= b_in;
                        r_count  <= '0;
                        r_ready  <= 1'b0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_aShift <= r_aShift >> 1;
                    r_bShift <= r_bShift >> 1;
                    r_dShift <= w_dShiftNext;
                    r_borrow <= w_borrowNext;
                    if (r_count == LAST) begin
                        r_count <= '0;
                        r_diff  <= w_dShiftNext;
                        r_bOut  <= w_borrowNext;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign done  = r_done;
    assign diff  = r_diff;
    assign b_out = r_bOut;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to begin an operation; sampled only while ready=1.
REQ-005 SHALL have port a, input, WIDTH, minuend; latched on the accepting edge.
REQ-006 SHALL have port b, input, WIDTH, subtrahend; latched on the accepting edge.
REQ-007 SHALL have port b_in, input, 1, borrow-in; latched on the accepting edge.
REQ-008 SHALL have port ready, output, 1, high only in IDLE (block can accept start).
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking a valid new result.
REQ-010 SHALL have port diff, output, WIDTH, registered difference.
REQ-011 SHALL have port b_out, output, 1, registered borrow-out.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL implement transition IDLE->RUN on an edge with start=1; a, b and b_in are latched, the bit counter is cleared, and the running borrow is set to b_in.
REQ-014 SHALL process one bit per RUN cycle, LSB first, using a 1-bit full subtractor: d = x^y^br, br' = (~x&y) | (~(x^y)&br).
REQ-015 SHALL, on the RUN edge where counter = WIDTH-1, load diff and b_out from the completed shift register and final borrow, and go RUN->DONE.
REQ-016 SHALL hold done=1 for exactly the one cycle spent in DONE, then go DONE->IDLE unconditionally.
REQ-017 SHALL have a latency such that done rises WIDTH cycles after the accepting edge; back-to-back start gives one result per WIDTH+2 cycles.
REQ-018 SHALL compute, arithmetically, {b_out, diff} = bits [WIDTH:0] of ({1'b0,a} - {1'b0,b} - b_in) in WIDTH+1-bit two's complement; b_out=1 iff a < b + b_in (unsigned).
REQ-019 SHALL ignore start in RUN or DONE, with no effect on the latched operands or the result.
REQ-020 SHALL ignore operand inputs changing outside the accepting edge.
REQ-021 SHALL change diff and b_out only on the completion edge of REQ-015; they hold their values through IDLE until the next completion.
REQ-022 SHALL treat start held high continuously as a new request on each IDLE cycle.
REQ-023 SHALL handle the counter wrap: the counter never exceeds WIDTH-1 and is cleared on acceptance.

Reset
REQ-024 SHALL, while rst=1 at an edge, set state IDLE, counter 0, shift register 0, diff 0, b_out 0 and done 0; ready=1 from the following cycle.
REQ-025 SHALL, on rst during RUN or DONE, abort the operation with no done pulse; the previous result is cleared to 0.
REQ-026 SHALL give rst priority over start on the same edge.

Structure
REQ-027 SHALL place the state enum typedef (IDLE/RUN/DONE) and the default WIDTH constant in shared package serial_sub_pkg.
REQ-028 SHALL instantiate the 1-bit combinational cell as sub-module full_subtractor_bit (ports x, y, br_in, d, br_out).
REQ-029 SHALL use a counter sized $clog2(WIDTH) bits, minimum 1.

Verification
REQ-030 SHALL cover: a=0x05, b=0x03, b_in=0, start pulse -> done exactly 8 cycles later, diff=0x02, b_out=0.
REQ-031 SHALL cover: a=0x00, b=0x01, b_in=0 -> diff=0xFF, b_out=1; then a=0xFF, b=0xFF, b_in=1 -> diff=0xFF, b_out=1.
REQ-032 SHALL cover: start pulsed with a=0x10, b=0x01, then start=1 with a=0x00 during RUN -> single done, diff=0x0F, b_out=0, ready low until the DONE->IDLE transition.
REQ-033 SHALL cover: rst asserted 4 cycles into RUN -> no done pulse, diff=0x00, b_out=0, ready=1 next cycle; a subsequent a=0x80, b=0x7F, b_in=0 -> diff=0x01, b_out=0.
REQ-034 SHALL cover: 100 random {a, b, b_in} with start held high -> each done matches REQ-018 via case-equality, with exactly WIDTH+2 cycles between done pulses.
